// File: rtl/uart_tx_drain_if.sv
// Read port of the TX data FIFO as seen by the serializer.
// The drain side owns the pop strobe; the FIFO side owns status and data.
interface uart_tx_drain_if #(
  parameter int DATA_BITS = 8
);
  logic                 avail;
  logic                 re;
  logic [DATA_BITS-1:0] rdata;

  modport master (input avail, input rdata, output re);
  modport slave  (output avail, output rdata, input re);
endinterface

// File: rtl/uart_tx_drain.sv
// UART transmit serializer that pops words from the TX FIFO and frames them.
// Every output is registered from the next-state values, so the line changes exactly on bit boundaries.
module uart_tx_drain #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_RSYNC = 1,
  parameter int DIV_W      = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [DIV_W-1:0]   i_baud_div,
  input  logic               i_parity_en,
  input  logic               i_parity_odd,
  input  logic               i_stop2,
  input  logic               i_cts,
  uart_tx_drain_if.master    fifo,
  output logic               o_txd,
  output logic               o_busy,
  output logic               o_done
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    WAIT,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DIV_W-1:0]     baud_cnt, baud_n;
  logic [CNT_W-1:0]     bit_cnt, bit_n;
  logic [DIV_W-1:0]     div_q, div_n;
  logic                 par_en_q, par_en_n;
  logic                 stop2_q, stop2_n;
  logic                 par_bit_q, par_bit_n;
  logic                 capture;
  logic                 re_q, re_n;
  logic                 txd_n, busy_n, done_n;

  assign fifo.re = re_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      shift     <= '0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      div_q     <= '0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      par_bit_q <= 1'b0;
      re_q      <= 1'b0;
      o_txd     <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state     <= state_n;
      shift     <= shift_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      div_q     <= div_n;
      par_en_q  <= par_en_n;
      stop2_q   <= stop2_n;
      par_bit_q <= par_bit_n;
      re_q      <= re_n;
      o_txd     <= txd_n;
      o_busy    <= busy_n;
      o_done    <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    baud_n    = baud_cnt;
    bit_n     = bit_cnt;
    div_n     = div_q;
    par_en_n  = par_en_q;
    stop2_n   = stop2_q;
    par_bit_n = par_bit_q;
    capture   = 1'b0;

    case (state)
      IDLE: begin
        if (i_cts && fifo.avail) state_n = POP;
      end
      POP: begin
        if (FIFO_RSYNC != 0) state_n = WAIT;
        else                 capture = 1'b1;
      end
      WAIT: begin
        capture = 1'b1;
      end
      START: begin
        if (baud_cnt == '0) begin
          state_n = DATA;
          baud_n  = div_q;
          bit_n   = '0;
        end else begin
          baud_n = baud_cnt - DIV_W'(1);
        end
      end
      DATA: begin
        if (baud_cnt == '0) begin
          baud_n  = div_q;
          shift_n = shift >> 1;
          if (bit_cnt == LAST_BIT) begin
            bit_n   = '0;
            state_n = par_en_q ? PARITY : STOP;
          end else begin
            bit_n = bit_cnt + CNT_W'(1);
          end
        end else begin
          baud_n = baud_cnt - DIV_W'(1);
        end
      end
      PARITY: begin
        if (baud_cnt == '0) begin
          baud_n  = div_q;
          bit_n   = '0;
          state_n = STOP;
        end else begin
          baud_n = baud_cnt - DIV_W'(1);
        end
      end
      STOP: begin
        // bit_cnt doubles as the stop-bit index when two stop bits are framed
        if (baud_cnt == '0) begin
          if (stop2_q && bit_cnt == '0) begin
            bit_n  = CNT_W'(1);
            baud_n = div_q;
          end else begin
            bit_n   = '0;
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt - DIV_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Parity is precomputed here because the shift register is consumed by the time it is sent
    if (capture) begin
      shift_n   = fifo.rdata;
      div_n     = i_baud_div;
      par_en_n  = i_parity_en;
      stop2_n   = i_stop2;
      par_bit_n = (^fifo.rdata) ^ i_parity_odd;
      baud_n    = i_baud_div;
      bit_n     = '0;
      state_n   = START;
    end

    if (!i_en) begin
      state_n = IDLE;
      baud_n  = '0;
      bit_n   = '0;
    end

    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shift_n[0];
      PARITY:  txd_n = par_bit_n;
      default: txd_n = 1'b1;
    endcase
    re_n   = (state_n == POP);
    busy_n = (state_n != IDLE);
    done_n = i_en && (state == STOP) && (state_n == IDLE);
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain: registered-read FIFO model on the main instance,
// plus a second instance in same-cycle read mode driven directly.
module tb_uart_tx_drain;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_en;
  logic [15:0] i_baud_div;
  logic        i_parity_en;
  logic        i_parity_odd;
  logic        i_stop2;
  logic        i_cts;
  logic        txd, busy, done;
  logic        txd_z, busy_z, done_z;

  int n_checks = 0;
  int n_bad    = 0;
  int re_count = 0;
  int done_count = 0;

  uart_tx_drain_if #(.DATA_BITS(8)) fifo ();
  uart_tx_drain_if #(.DATA_BITS(8)) fz ();

  uart_tx_drain #(.DATA_BITS(8), .FIFO_RSYNC(1), .DIV_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_baud_div(i_baud_div),
    .i_parity_en(i_parity_en), .i_parity_odd(i_parity_odd), .i_stop2(i_stop2),
    .i_cts(i_cts), .fifo(fifo), .o_txd(txd), .o_busy(busy), .o_done(done)
  );

  uart_tx_drain #(.DATA_BITS(8), .FIFO_RSYNC(0), .DIV_W(16)) dut_z (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_baud_div(i_baud_div),
    .i_parity_en(i_parity_en), .i_parity_odd(i_parity_odd), .i_stop2(i_stop2),
    .i_cts(i_cts), .fifo(fz), .o_txd(txd_z), .o_busy(busy_z), .o_done(done_z)
  );

  always #5 i_clk = ~i_clk;

  // FIFO model whose read data appears the cycle after the pop
  logic [7:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo.avail = (wr_ptr != rd_ptr);

  always @(posedge i_clk) begin
    if (fifo.re && (wr_ptr != rd_ptr)) begin
      fifo.rdata <= mem[rd_ptr % 16];
      rd_ptr     <= rd_ptr + 1;
    end
    if (fifo.re) re_count <= re_count + 1;
    if (done) done_count <= done_count + 1;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks = n_checks + 1;
    if (observed !== expected) begin
      n_bad = n_bad + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic pushWord(input logic [7:0] w);
    mem[wr_ptr % 16] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  function automatic logic txdSel(input bit which);
    return which ? txd_z : txd;
  endfunction

  function automatic logic doneSel(input bit which);
    return which ? done_z : done;
  endfunction

  task automatic waitStart(input bit which, input string tag);
    int n;
    n = 0;
    while (txdSel(which) !== 1'b0 && n < 40) begin
      tick(1);
      n = n + 1;
    end
    checkOutput({tag, " start seen"}, txdSel(which), 1'b0);
  endtask

  // Called in the first start-bit cycle; returns in the cycle after the last stop bit
  task automatic checkFrame(input bit which, input logic [7:0] data, input bit par_en,
                            input bit par_odd, input bit stop2, input int div, input string tag);
    logic [11:0] exp_bits;
    int nb;
    exp_bits = '1;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = data[i];
    nb = 9;
    if (par_en) begin
      exp_bits[nb] = (^data) ^ par_odd;
      nb = nb + 1;
    end
    nb = nb + (stop2 ? 2 : 1);
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c <= div; c++) begin
        checkOutput($sformatf("%s b%0d c%0d", tag, b, c), txdSel(which), exp_bits[b]);
        tick(1);
      end
    end
    checkOutput({tag, " done"}, doneSel(which), 1'b1);
  endtask

  task automatic applyStimulus(input logic [15:0] div, input bit par_en, input bit par_odd, input bit stop2);
    i_baud_div   = div;
    i_parity_en  = par_en;
    i_parity_odd = par_odd;
    i_stop2      = stop2;
  endtask

  int re0, done0, gap, hits;

  initial begin
    i_rst = 1'b1;
    i_en  = 1'b1;
    i_cts = 1'b1;
    fz.avail = 1'b0;
    fz.rdata = 8'h00;
    applyStimulus(16'd3, 1'b0, 1'b0, 1'b0);
    tick(2);
    checkOutput("reset txd", txd, 1'b1);
    checkOutput("reset re", fifo.re, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset done", done, 1'b0);
    i_rst = 1'b0;
    tick(3);

    $display("[TB] 8N1 div=3 0xA5");
    re0 = re_count;
    pushWord(8'hA5);
    tick(1);
    checkOutput("a5 re t+1", fifo.re, 1'b1);
    checkOutput("a5 busy t+1", busy, 1'b1);
    tick(1);
    checkOutput("a5 re t+2", fifo.re, 1'b0);
    checkOutput("a5 txd t+2", txd, 1'b1);
    tick(1);
    applyStimulus(16'd7, 1'b1, 1'b1, 1'b1);
    checkFrame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 3, "a5");
    tick(1);
    checkOutput("a5 done width", done, 1'b0);
    checkOutput("a5 pops", re_count - re0, 1);

    $display("[TB] parity div=0");
    applyStimulus(16'd0, 1'b1, 1'b0, 1'b1);
    pushWord(8'hA5);
    waitStart(1'b0, "8e2");
    checkFrame(1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 0, "8e2");
    applyStimulus(16'd0, 1'b1, 1'b1, 1'b0);
    pushWord(8'hA5);
    waitStart(1'b0, "8o1");
    checkFrame(1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 0, "8o1");
    tick(2);

    $display("[TB] back-to-back");
    applyStimulus(16'd1, 1'b0, 1'b0, 1'b0);
    re0 = re_count;
    done0 = done_count;
    pushWord(8'h00);
    pushWord(8'hFF);
    waitStart(1'b0, "b2b0");
    checkFrame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1, "b2b0");
    gap = 0;
    while (txd === 1'b1 && gap < 20) begin
      gap = gap + 1;
      tick(1);
    end
    checkOutput("b2b gap", gap, 3);
    checkFrame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1, "b2b1");
    tick(4);
    checkOutput("b2b pops", re_count - re0, 2);
    checkOutput("b2b dones", done_count - done0, 2);

    $display("[TB] flow control");
    i_cts = 1'b0;
    re0 = re_count;
    pushWord(8'h3C);
    hits = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (fifo.re !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) hits = hits + 1;
    end
    checkOutput("cts hold activity", hits, 0);
    checkOutput("cts hold pops", re_count - re0, 0);
    i_cts = 1'b1;
    tick(1);
    checkOutput("cts pop", fifo.re, 1'b1);
    tick(2);
    i_cts = 1'b0;
    checkFrame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1, "cts drop");
    i_cts = 1'b1;
    tick(2);

    $display("[TB] abort");
    re0 = re_count;
    done0 = done_count;
    pushWord(8'h52);
    pushWord(8'hC3);
    waitStart(1'b0, "abort");
    tick(8);
    checkOutput("abort bit3", txd, 1'b0);
    i_en = 1'b0;
    tick(1);
    checkOutput("abort txd", txd, 1'b1);
    checkOutput("abort busy", busy, 1'b0);
    checkOutput("abort done", done, 1'b0);
    tick(4);
    checkOutput("abort no done", done_count - done0, 0);
    checkOutput("abort pops", re_count - re0, 1);
    i_en = 1'b1;
    waitStart(1'b0, "resume");
    checkFrame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 1, "resume");
    tick(2);

    $display("[TB] reset mid-parity");
    applyStimulus(16'd3, 1'b1, 1'b0, 1'b0);
    pushWord(8'h0F);
    waitStart(1'b0, "rst");
    tick(36);
    checkOutput("rst parity bit", txd, 1'b0);
    checkOutput("rst busy before", busy, 1'b1);
    #2;
    i_rst = 1'b1;
    #1;
    checkOutput("rst txd", txd, 1'b1);
    checkOutput("rst busy", busy, 1'b0);
    checkOutput("rst re", fifo.re, 1'b0);
    tick(1);
    i_rst = 1'b0;
    re0 = re_count;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (txd !== 1'b1) hits = hits + 1;
    end
    checkOutput("post rst pops", re_count - re0, 0);
    checkOutput("post rst txd", hits, 0);

    $display("[TB] same-cycle read mode");
    applyStimulus(16'd0, 1'b0, 1'b0, 1'b0);
    fz.rdata = 8'h96;
    fz.avail = 1'b1;
    tick(1);
    checkOutput("rsync0 re", fz.re, 1'b1);
    checkOutput("rsync0 busy", busy_z, 1'b1);
    fz.avail = 1'b0;
    tick(1);
    checkFrame(1'b1, 8'h96, 1'b0, 1'b0, 1'b0, 0, "rsync0");
    tick(1);
    checkOutput("rsync0 idle re", fz.re, 1'b0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
